morse_decoder_basic: RTL and testbench
======================================

Name: morse_decoder_basic

Overview:
- Receiver side of the Morse digit path: samples a single Morse key and times each press as dot or dash.
- Collects 5-symbol digit codes and converts each completed code to an active-low 7-segment pattern.
- Shifts each decoded digit into an 8-digit display word, seg_out_temp. This is the same word the encoder side reads: digit 1 in [7:0], digit 8 in [63:56], 8'hFF = blank.
- Closes the loop between key input and display/encoder.

Parameters:
- GLITCH_CYCLES, 2: minimum press length in clk cycles. Shorter presses are ignored.
- DASH_CYCLES, 8: press length ≥ this is a dash, otherwise a dot. Must be > GLITCH_CYCLES.
- GAP_CYCLES, 16: release length that ends a digit. Must be > DASH_CYCLES.
- CNT_W, 16: width of the press/gap counters. Counters saturate at all-ones.

Ports:
- clk, input, 1: system clock. All logic is on the rising edge.
- rst, input, 1: synchronous, active-low reset.
- key, input, 1: Morse key, active-high, asynchronous to clk.
- clear, input, 1: synchronous. Blanks the display word and aborts any partial digit.
- seg_out_temp, output, 64: display word of 8 active-low 7-seg bytes. The newest digit is in [7:0].
- morse_code, output, 5: last completed code. bit4 = first symbol; 0 = dot, 1 = dash.
- digit_valid, output, 1: one-cycle pulse when a digit is committed.
- err, output, 1: one-cycle pulse when a code is rejected.

Behaviour:
- Reset (rst=0 at a clk edge), all registers:
  - seg_out_temp = 64'hFFFF_FFFF_FFFF_FFFF; morse_code = 5'b10101; digit_valid = 0; err = 0.
  - Symbol count = 0; FSM = IDLE; both synchronizer flops = 0.
  - Reset has priority over everything, including mid-press or mid-gap.
- key passes through a 2-flop synchronizer → key_s. All timing below refers to key_s.
- FSM states: IDLE, PRESS, GAP.
  - IDLE: key_s=1 → PRESS, press_cnt=1.
  - PRESS: while key_s=1, press_cnt increments (saturating). On key_s=0:
    - If press_cnt < GLITCH_CYCLES, the press is discarded. Return to GAP if sym_cnt>0, else IDLE.
    - Otherwise the symbol is dot (press_cnt < DASH_CYCLES) or dash. Shift it into code_sr from the LSB, sym_cnt+1, → GAP with gap_cnt=1.
    - If sym_cnt is already 5, the 6th symbol sets an overflow flag and is not stored.
  - GAP: key_s=1 → PRESS, press_cnt=1, gap_cnt cleared. Otherwise gap_cnt increments. When gap_cnt reaches GAP_CYCLES, commit on the next edge and go to IDLE.
- Commit:
  - Valid when sym_cnt==5 and no overflow.
  - Lookup (code → seg byte):
    - 01111 → F9 (1)
    - 00111 → A4 (2)
    - 00011 → B0 (3)
    - 00001 → 99 (4)
    - 00000 → 92 (5)
    - 10000 → 82 (6)
    - 11000 → F8 (7)
    - 11100 → 80 (8)
    - 11110 → 90 (9)
    - 11111 → C0 (0)
  - Valid code: seg_out_temp ← {seg_out_temp[55:0], seg_byte}; morse_code ← code; digit_valid=1 for exactly one cycle, the same cycle the new seg_out_temp first appears.
  - Invalid (sym_cnt≠5, or overflow): seg_out_temp and morse_code unchanged; err=1 for one cycle.
  - sym_cnt, code_sr and overflow clear in both cases.
  - Oldest digit [63:56] is dropped on each shift (wrap-around by discard).
- Latency: digit_valid asserts GAP_CYCLES+1 edges after the edge where key_s first reads 0 after the last press. This is 2 more edges from raw key because of the synchronizer.
- clear=1: seg_out_temp ← all FF, sym_cnt/code_sr/overflow ← 0, FSM → IDLE if in GAP. morse_code is unchanged. clear overrides a commit in the same cycle; no digit_valid or err is raised.
- A press running at saturation stays a dash. gap_cnt never exceeds GAP_CYCLES.
- digit_valid and err are never high together.

Test Plan:
- Reset: hold rst=0 for 3 cycles with key toggling → seg_out_temp=all FF, morse_code=10101, no pulses, FSM IDLE.
- Key dot (4 cycles) then dash ×4 (12 cycles each), gaps of 4 cycles, then idle 20 cycles → digit_valid pulse once; morse_code=01111; seg_out_temp[7:0]=F9, [63:8] all FF.
- All ten digits entered in order 1..9,0 → after the 8th digit, seg_out_temp=F9A4B09992 82F880 (digit 1 in [63:56]). After 9 and 0: [15:8]=90, [7:0]=C0, 1 and 2 dropped.
- 1-cycle key glitches between valid symbols → ignored; the code still decodes correctly. A glitch alone in IDLE produces no pulse.
- Three dots then gap → err pulse, seg_out_temp unchanged. Six dots then gap → err pulse (overflow), code not 00000.
- Assert clear mid-digit after 2 symbols, then enter 00000 → seg_out_temp=FFFF_FFFF_FFFF_FF92. rst=0 asserted mid-press → full reset values next cycle; the interrupted press is never committed.

Source files
------------

// File: rtl/morse_decoder_basic.sv
// Morse key receiver: times each key press as a dot or a dash, collects 5-symbol digit
// codes, and shifts each decoded active-low 7-segment byte into an 8-digit display word.
module morse_decoder_basic #(
  parameter int GLITCH_CYCLES = 2,
  parameter int DASH_CYCLES   = 8,
  parameter int GAP_CYCLES    = 16,
  parameter int CNT_W         = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        key,
  input  logic        clear,
  output logic [63:0] seg_out_temp,
  output logic [4:0]  morse_code,
  output logic        digit_valid,
  output logic        err
);

  typedef enum logic [1:0] {IDLE, PRESS, GAP} state_t;

  localparam logic [CNT_W-1:0] GLITCH_C = CNT_W'(GLITCH_CYCLES);
  localparam logic [CNT_W-1:0] DASH_C   = CNT_W'(DASH_CYCLES);
  localparam logic [CNT_W-1:0] GAP_C    = CNT_W'(GAP_CYCLES);
  localparam logic [CNT_W-1:0] ONE_C    = CNT_W'(1);

  state_t             state, state_nx;
  logic [1:0]         sync_pipe;
  logic               key_s;
  logic [CNT_W-1:0]   press_cnt, press_nx;
  logic [CNT_W-1:0]   gap_cnt, gap_nx;
  logic [4:0]         code_sr, code_nx;
  logic [2:0]         sym_cnt, sym_nx;
  logic               ovf, ovf_nx;

  // Commit is split over two edges: the decision edge snapshots the code, the next edge
  // updates the display together with the pulse.
  logic               cm_pend, cm_pend_nx;
  logic               cm_ok, cm_ok_nx;
  logic [4:0]         cm_code, cm_code_nx;
  logic [7:0]         cm_seg, cm_seg_nx;

  logic [63:0]        seg_nx;
  logic [4:0]         mc_nx;
  logic               dv_nx, err_nx;
  logic               lut_hit;
  logic [7:0]         lut_seg;
  logic               sym_dash;

  assign key_s    = sync_pipe[1];
  assign sym_dash = (press_cnt >= DASH_C);

  always_comb begin
    lut_hit = 1'b1;
    lut_seg = 8'hFF;
    case (code_sr)
      5'b01111: lut_seg = 8'hF9;
      5'b00111: lut_seg = 8'hA4;
      5'b00011: lut_seg = 8'hB0;
      5'b00001: lut_seg = 8'h99;
      5'b00000: lut_seg = 8'h92;
      5'b10000: lut_seg = 8'h82;
      5'b11000: lut_seg = 8'hF8;
      5'b11100: lut_seg = 8'h80;
      5'b11110: lut_seg = 8'h90;
      5'b11111: lut_seg = 8'hC0;
      default:  lut_hit = 1'b0;
    endcase
  end

  always_comb begin
    state_nx   = state;
    press_nx   = press_cnt;
    gap_nx     = gap_cnt;
    code_nx    = code_sr;
    sym_nx     = sym_cnt;
    ovf_nx     = ovf;
    cm_pend_nx = 1'b0;
    cm_ok_nx   = cm_ok;
    cm_code_nx = cm_code;
    cm_seg_nx  = cm_seg;
    seg_nx     = seg_out_temp;
    mc_nx      = morse_code;
    dv_nx      = 1'b0;
    err_nx     = 1'b0;

    case (state)
      IDLE: begin
        if (key_s) begin
          state_nx = PRESS;
          press_nx = ONE_C;
        end
      end
      PRESS: begin
        if (key_s) begin
          if (press_cnt != '1) press_nx = press_cnt + ONE_C;
        end else if (press_cnt < GLITCH_C) begin
          state_nx = (sym_cnt != 3'd0) ? GAP : IDLE;
        end else begin
          if (sym_cnt == 3'd5) begin
            ovf_nx = 1'b1;
          end else begin
            code_nx = {code_sr[3:0], sym_dash};
            sym_nx  = sym_cnt + 3'd1;
          end
          state_nx = GAP;
          gap_nx   = ONE_C;
        end
      end
      GAP: begin
        if (key_s) begin
          state_nx = PRESS;
          press_nx = ONE_C;
          gap_nx   = '0;
        end else if (gap_cnt >= GAP_C) begin
          state_nx   = IDLE;
          gap_nx     = '0;
          cm_pend_nx = 1'b1;
          cm_ok_nx   = (sym_cnt == 3'd5) && !ovf && lut_hit;
          cm_code_nx = code_sr;
          cm_seg_nx  = lut_seg;
          code_nx    = '0;
          sym_nx     = '0;
          ovf_nx     = 1'b0;
        end else begin
          gap_nx = gap_cnt + ONE_C;
        end
      end
      default: state_nx = IDLE;
    endcase

    if (cm_pend) begin
      if (cm_ok) begin
        seg_nx = {seg_out_temp[55:0], cm_seg};
        mc_nx  = cm_code;
        dv_nx  = 1'b1;
      end else begin
        err_nx = 1'b1;
      end
    end

    // clear wins over any commit in flight; a press in progress is left to finish
    if (clear) begin
      seg_nx     = '1;
      mc_nx      = morse_code;
      dv_nx      = 1'b0;
      err_nx     = 1'b0;
      cm_pend_nx = 1'b0;
      code_nx    = '0;
      sym_nx     = '0;
      ovf_nx     = 1'b0;
      if (state_nx == GAP) begin
        state_nx = IDLE;
        gap_nx   = '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      sync_pipe    <= '0;
      state        <= IDLE;
      press_cnt    <= '0;
      gap_cnt      <= '0;
      code_sr      <= '0;
      sym_cnt      <= '0;
      ovf          <= 1'b0;
      cm_pend      <= 1'b0;
      cm_ok        <= 1'b0;
      cm_code      <= '0;
      cm_seg       <= 8'hFF;
      seg_out_temp <= '1;
      morse_code   <= 5'b10101;
      digit_valid  <= 1'b0;
      err          <= 1'b0;
    end else begin
      sync_pipe    <= {sync_pipe[0], key};
      state        <= state_nx;
      press_cnt    <= press_nx;
      gap_cnt      <= gap_nx;
      code_sr      <= code_nx;
      sym_cnt      <= sym_nx;
      ovf          <= ovf_nx;
      cm_pend      <= cm_pend_nx;
      cm_ok        <= cm_ok_nx;
      cm_code      <= cm_code_nx;
      cm_seg       <= cm_seg_nx;
      seg_out_temp <= seg_nx;
      morse_code   <= mc_nx;
      digit_valid  <= dv_nx;
      err          <= err_nx;
    end
  end

endmodule

// File: tb/tb_morse_decoder_basic.sv
// Bench for morse_decoder_basic: directed key sequences feed a scoreboard queue of
// expected commits; a monitor pops and checks on every digit_valid/err pulse.
module tb_morse_decoder_basic;

  logic        clk = 1'b0;
  logic        rst;
  logic        key;
  logic        clear;
  logic [63:0] seg_out_temp;
  logic [4:0]  morse_code;
  logic        digit_valid;
  logic        err;

  morse_decoder_basic dut (
    .clk(clk), .rst(rst), .key(key), .clear(clear),
    .seg_out_temp(seg_out_temp), .morse_code(morse_code),
    .digit_valid(digit_valid), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        is_err;
    logic [63:0] seg;
    logic [4:0]  code;
  } exp_t;

  exp_t        sbq[$];
  int          total = 0;
  int          bad   = 0;
  logic [63:0] seg_m;
  logic [4:0]  code_m;

  logic [4:0] codes[10] = '{5'b01111, 5'b00111, 5'b00011, 5'b00001, 5'b00000,
                            5'b10000, 5'b11000, 5'b11100, 5'b11110, 5'b11111};
  logic [7:0] segs[10]  = '{8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92,
                            8'h82, 8'hF8, 8'h80, 8'h90, 8'hC0};

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic press(input int n);
    key = 1'b1;
    tick(n);
    key = 1'b0;
  endtask

  task automatic sym(input logic dash);
    press(dash ? 12 : 4);
    tick(4);
  endtask

  task automatic exp_digit(input logic [4:0] c, input logic [7:0] b);
    exp_t e;
    seg_m  = {seg_m[55:0], b};
    code_m = c;
    e.is_err = 1'b0; e.seg = seg_m; e.code = code_m;
    sbq.push_back(e);
  endtask

  task automatic exp_err();
    exp_t e;
    e.is_err = 1'b1; e.seg = seg_m; e.code = code_m;
    sbq.push_back(e);
  endtask

  task automatic digit(input logic [4:0] c, input logic [7:0] b);
    for (int i = 4; i >= 0; i--) sym(c[i]);
    exp_digit(c, b);
    tick(24);
  endtask

  // monitor
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (digit_valid || err) begin
        chk("pulse_exclusive", 64'(digit_valid & err), 64'(0));
        if (sbq.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_pulse: got dv=%0b err=%0b want none", digit_valid, err);
        end else begin
          e = sbq.pop_front();
          chk("pulse_kind_err", 64'(err), 64'(e.is_err));
          chk("seg_out_temp", seg_out_temp, e.seg);
          chk("morse_code", 64'(morse_code), 64'(e.code));
        end
      end
    end
  end

  initial begin
    int k;
    rst = 1'b0; key = 1'b0; clear = 1'b0;
    seg_m = '1; code_m = 5'b10101;

    // reset with the key toggling
    for (int i = 0; i < 3; i++) begin
      key = ~key;
      tick(1);
    end
    key = 1'b0;
    chk("rst_seg", seg_out_temp, 64'hFFFF_FFFF_FFFF_FFFF);
    chk("rst_code", 64'(morse_code), 64'(5'b10101));
    chk("rst_dv", 64'(digit_valid), 64'(0));
    chk("rst_err", 64'(err), 64'(0));
    rst = 1'b1;
    tick(20);

    // digit 1 (dot, 4 dashes), with commit latency measured from raw key release
    sym(1'b0); sym(1'b1); sym(1'b1); sym(1'b1);
    press(12);
    exp_digit(5'b01111, 8'hF9);
    k = 0;
    while (k < 40) begin
      tick(1);
      k++;
      if (digit_valid) break;
    end
    chk("commit_latency", 64'(k), 64'(20));
    tick(10);
    chk("digit1_word", seg_out_temp, 64'hFFFF_FFFF_FFFF_FFF9);

    // digits 1..9,0
    for (int d = 0; d < 8; d++) digit(codes[d], segs[d]);
    chk("eight_digits", seg_out_temp, 64'hF9A4_B099_9282_F880);
    digit(codes[8], segs[8]);
    digit(codes[9], segs[9]);
    chk("ten_digits", seg_out_temp, 64'hB099_9282_F880_90C0);

    // digit 3 with a 1-cycle glitch inside every gap
    for (int i = 4; i >= 0; i--) begin
      press(codes[2][i] ? 12 : 4);
      tick(2);
      press(1);
      tick(3);
    end
    exp_digit(5'b00011, 8'hB0);
    tick(24);

    // lone glitch while idle: no pulse
    press(1);
    tick(30);

    // three dots: too short
    for (int i = 0; i < 3; i++) sym(1'b0);
    exp_err();
    tick(24);

    // six dots: overflow
    for (int i = 0; i < 6; i++) sym(1'b0);
    exp_err();
    tick(24);
    chk("overflow_code_kept", 64'(morse_code), 64'(5'b00011));

    // clear mid-digit after two symbols, then enter 5
    sym(1'b1); sym(1'b0);
    clear = 1'b1;
    tick(1);
    clear = 1'b0;
    seg_m = '1;
    chk("clear_seg", seg_out_temp, 64'hFFFF_FFFF_FFFF_FFFF);
    chk("clear_code_kept", 64'(morse_code), 64'(code_m));
    digit(5'b00000, 8'h92);
    chk("after_clear_word", seg_out_temp, 64'hFFFF_FFFF_FFFF_FF92);

    // reset in the middle of a press
    key = 1'b1;
    tick(6);
    rst = 1'b0;
    key = 1'b0;
    tick(1);
    seg_m = '1; code_m = 5'b10101;
    chk("midpress_rst_seg", seg_out_temp, 64'hFFFF_FFFF_FFFF_FFFF);
    chk("midpress_rst_code", 64'(morse_code), 64'(5'b10101));
    chk("midpress_rst_dv", 64'(digit_valid), 64'(0));
    rst = 1'b1;
    tick(40);

    chk("scoreboard_empty", 64'(sbq.size()), 64'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
